// File: rtl/user_timer_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_timer_obi_pkg
// Description : Shared types and constants for the user-domain OBI timer:
//               OBI request/response structs, register map offsets, control
//               bitfield layout and a byte-enable merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package user_timer_obi_pkg;

   localparam int unsigned ObiAddrWidth = 32;
   localparam int unsigned ObiDataWidth = 32;
   localparam int unsigned ObiIdWidth   = 3;

   // Base of the 4 KiB window this subordinate answers on the user demux
   localparam logic [31:0] UserTimerBase = 32'h2000_1000;

   typedef struct packed {
      logic                        req;
      logic [ObiAddrWidth-1:0]     addr;
      logic                        we;
      logic [ObiDataWidth/8-1:0]   be;
      logic [ObiDataWidth-1:0]     wdata;
      logic [ObiIdWidth-1:0]       aid;
   } sbr_obi_req_t;

   typedef struct packed {
      logic                        gnt;
      logic                        rvalid;
      logic [ObiDataWidth-1:0]     rdata;
      logic [ObiIdWidth-1:0]       rid;
      logic                        err;
   } sbr_obi_rsp_t;

   // Register byte offsets inside the window (decoded on addr[11:2])
   localparam logic [11:0] UserTimerCtrlOff    = 12'h000;
   localparam logic [11:0] UserTimerPrescOff   = 12'h004;
   localparam logic [11:0] UserTimerCountLoOff = 12'h008;
   localparam logic [11:0] UserTimerCountHiOff = 12'h00C;
   localparam logic [11:0] UserTimerCmpLoOff   = 12'h010;
   localparam logic [11:0] UserTimerCmpHiOff   = 12'h014;
   localparam logic [11:0] UserTimerStatusOff  = 12'h018;

   // CTRL register: bit 0 EN, bit 1 CLR_ON_MATCH, bit 2 IRQ_EN
   typedef struct packed {
      logic irq_en;
      logic clr_on_match;
      logic en;
   } user_timer_ctrl_t;

   // Replace only the bytes selected by be, keep the rest of old_word
   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/user_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : user_timer_prescaler
// Description : Divides the clock by (presc + 1) while enabled. Emits a
//               one-cycle tick when the phase counter reaches presc. A load
//               (bus write of the prescale value) restarts the phase at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module user_timer_prescaler #(
   parameter int unsigned PrescW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [PrescW-1:0] presc,
   output logic              tick
);

   logic [PrescW-1:0] psc_q;
   logic              at_end;

   assign at_end = (psc_q == presc);

   // A prescale reload suppresses the tick of that cycle: the phase restarts
   assign tick = en & ~load & at_end;

   // Phase counter: reload to 0, else count 0..presc while enabled, else hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
      end else if (load) begin
         psc_q <= '0;
      end else if (en) begin
         psc_q <= at_end ? '0 : psc_q + PrescW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/user_timer_obi.sv
`default_nettype none
// ============================================================================
// Module      : user_timer_obi
// Description : OBI subordinate holding a 64-bit prescaled up-counter, a
//               64-bit compare value and a registered level interrupt.
//               Grant is always high; every accepted request gets exactly one
//               response beat on the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module user_timer_obi
   import user_timer_obi_pkg::*;
#(
   parameter type         obi_req_t = sbr_obi_req_t,
   parameter type         obi_rsp_t = sbr_obi_rsp_t,
   parameter int unsigned PrescW    = 16
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t obi_req_i,
   output obi_rsp_t obi_rsp_o,
   output logic     irq_o
);

   logic [11:0]       reg_off;
   logic              acc;
   logic              wr;
   logic              rd;
   logic              mapped;
   logic [31:0]       reg_word;
   logic [31:0]       wr_word;
   logic [31:0]       rdata_d;

   user_timer_ctrl_t  ctrl_q;
   logic [PrescW-1:0] presc_q;
   logic [63:0]       count_q;
   logic [63:0]       cmp_q;
   logic [31:0]       shadow_q;
   logic              pending_q;
   logic              irq_q;

   logic              presc_load;
   logic              tick;
   logic              match;
   logic              status_clr;
   logic              count_lo_wr;
   logic              count_hi_wr;

   obi_rsp_t          rsp_q;
   logic              unused_addr;

   // Grant is tied high, so every request is accepted in its own cycle
   assign acc = obi_req_i.req;
   assign wr  = acc &  obi_req_i.we;
   assign rd  = acc & ~obi_req_i.we;

   // Word-aligned offset inside the 4 KiB window; byte lane bits ignored
   assign reg_off     = {obi_req_i.addr[11:2], 2'b00};
   assign unused_addr = ^{obi_req_i.addr[31:12], obi_req_i.addr[1:0]};

   // Raw contents of the addressed register and whether the offset is mapped
   always_comb begin
      mapped   = 1'b1;
      reg_word = '0;
      case (reg_off)
         UserTimerCtrlOff:    reg_word = 32'(ctrl_q);
         UserTimerPrescOff:   reg_word = 32'(presc_q);
         UserTimerCountLoOff: reg_word = count_q[31:0];
         UserTimerCountHiOff: reg_word = count_q[63:32];
         UserTimerCmpLoOff:   reg_word = cmp_q[31:0];
         UserTimerCmpHiOff:   reg_word = cmp_q[63:32];
         UserTimerStatusOff:  reg_word = {31'd0, pending_q};
         default:             mapped   = 1'b0;
      endcase
   end

   // Byte-enable write value for whichever register is addressed
   assign wr_word = be_merge(reg_word, obi_req_i.wdata, obi_req_i.be);

   // Read data: COUNT_HI returns the value latched by the last COUNT_LO read
   always_comb begin
      rdata_d = '0;
      if (rd && mapped) begin
         rdata_d = (reg_off == UserTimerCountHiOff) ? shadow_q : reg_word;
      end
   end

   assign presc_load  = wr && (reg_off == UserTimerPrescOff);
   assign count_lo_wr = wr && (reg_off == UserTimerCountLoOff);
   assign count_hi_wr = wr && (reg_off == UserTimerCountHiOff);
   assign status_clr  = wr && (reg_off == UserTimerStatusOff) &&
                        obi_req_i.be[0] && obi_req_i.wdata[0];

   // Compare uses the pre-increment count and only fires on a tick
   assign match = tick && (count_q == cmp_q);

   user_timer_prescaler #(
      .PrescW (PrescW)
   ) i_prescaler (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (ctrl_q.en),
      .load  (presc_load),
      .presc (presc_q),
      .tick  (tick)
   );

   // Configuration registers: CTRL, PRESCALE and the compare value
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         cmp_q   <= '1;
      end else if (wr) begin
         case (reg_off)
            UserTimerCtrlOff:  ctrl_q          <= user_timer_ctrl_t'(wr_word[2:0]);
            UserTimerPrescOff: presc_q         <= wr_word[PrescW-1:0];
            UserTimerCmpLoOff: cmp_q[31:0]     <= wr_word;
            UserTimerCmpHiOff: cmp_q[63:32]    <= wr_word;
            default:           ;
         endcase
      end
   end

   // Counter: a bus write to either half wins over the tick of that cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (count_lo_wr) begin
         count_q[31:0] <= wr_word;
      end else if (count_hi_wr) begin
         count_q[63:32] <= wr_word;
      end else if (tick) begin
         count_q <= (match && ctrl_q.clr_on_match) ? 64'd0 : count_q + 64'd1;
      end
   end

   // Pending flag: a match in the same cycle wins over the write-1-to-clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= 1'b0;
      end else if (match) begin
         pending_q <= 1'b1;
      end else if (status_clr) begin
         pending_q <= 1'b0;
      end
   end

   // Upper count half captured on a COUNT_LO read for tear-free 64-bit reads
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
      end else if (rd && (reg_off == UserTimerCountLoOff)) begin
         shadow_q <= count_q[63:32];
      end
   end

   // Registered interrupt; clearing IRQ_EN masks it without touching PENDING
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= pending_q & ctrl_q.irq_en;
      end
   end

   // R-channel response register, one beat per accepted request
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_q <= '0;
      end else begin
         rsp_q.gnt    <= 1'b0;
         rsp_q.rvalid <= acc;
         rsp_q.rid    <= obi_req_i.aid;
         rsp_q.err    <= acc & ~mapped;
         rsp_q.rdata  <= rdata_d;
      end
   end

   // Drive the response with grant forced high
   always_comb begin
      obi_rsp_o     = rsp_q;
      obi_rsp_o.gnt = 1'b1;
   end

   assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_user_timer_obi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_user_timer_obi
// Description : Scoreboard bench for user_timer_obi. The driver steps a
//               behavioural timer model each cycle and queues the expected
//               response beat; a monitor pops and compares on every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_timer_obi;
   import user_timer_obi_pkg::*;

   localparam int unsigned PRESC_W = 16;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   sbr_obi_req_t bus_req;
   sbr_obi_rsp_t bus_rsp;
   logic         irq;

   user_timer_obi #(
      .obi_req_t (sbr_obi_req_t),
      .obi_rsp_t (sbr_obi_rsp_t),
      .PrescW    (PRESC_W)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .obi_req_i (bus_req),
      .obi_rsp_o (bus_rsp),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]           rdata;
      logic                  err;
      logic [ObiIdWidth-1:0] rid;
      string                 name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state (register values as the bus sees them)
   bit                 m_en, m_clr, m_ien, m_pend, m_irq;
   logic [PRESC_W-1:0] m_presc, m_phase;
   logic [63:0]        m_cnt, m_cmp;
   logic [31:0]        m_shadow;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_en = 0; m_clr = 0; m_ien = 0; m_pend = 0; m_irq = 0;
      m_presc = '0; m_phase = '0;
      m_cnt = '0; m_cmp = '1; m_shadow = '0;
      exp_q.delete();
   endtask

   // Advance the model by one clock edge carrying the given request
   task automatic model_step(input bit rq, input bit we, input logic [11:0] off_b,
                             input logic [3:0] be, input logic [31:0] wd,
                             input logic [ObiIdWidth-1:0] aid, input string name,
                             input bit fx, input logic [31:0] fv);
      int          w;
      bit          wr, rd, known, tick, hit;
      logic [31:0] rv, t;
      logic [63:0] cnt0;
      exp_t        e;
      w = int'(off_b[11:2]);
      wr = rq && we;
      rd = rq && !we;
      known = (w <= 6);
      cnt0 = m_cnt;
      rv = 0;
      if (rd) begin
         case (w)
            0: rv = {29'd0, m_ien, m_clr, m_en};
            1: rv = 32'(m_presc);
            2: rv = m_cnt[31:0];
            3: rv = m_shadow;
            4: rv = m_cmp[31:0];
            5: rv = m_cmp[63:32];
            6: rv = {31'd0, m_pend};
            default: rv = 0;
         endcase
      end
      if (rq) begin
         e.rdata = fx ? fv : rv;
         e.err = !known;
         e.rid = aid;
         e.name = name;
         exp_q.push_back(e);
      end
      // Timer behaviour for this cycle, from the values before the bus write
      tick = m_en && !(wr && w == 1) && (m_phase == m_presc);
      hit = tick && (cnt0 == m_cmp);
      m_irq = m_pend && m_ien;
      if (rd && w == 2) m_shadow = cnt0[63:32];
      if (hit) m_pend = 1;
      else if (wr && w == 6 && be[0] && wd[0]) m_pend = 0;
      if (wr && w == 1) m_phase = '0;
      else if (tick) m_phase = '0;
      else if (m_en) m_phase = m_phase + PRESC_W'(1);
      if (tick) m_cnt = (hit && m_clr) ? 64'd0 : cnt0 + 64'd1;
      if (wr) begin
         case (w)
            0: begin
               t = merge({29'd0, m_ien, m_clr, m_en}, wd, be);
               m_en = t[0]; m_clr = t[1]; m_ien = t[2];
            end
            1: begin t = merge(32'(m_presc), wd, be); m_presc = t[PRESC_W-1:0]; end
            2: m_cnt = {cnt0[63:32], merge(cnt0[31:0], wd, be)};
            3: m_cnt = {merge(cnt0[63:32], wd, be), cnt0[31:0]};
            4: m_cmp[31:0] = merge(m_cmp[31:0], wd, be);
            5: m_cmp[63:32] = merge(m_cmp[63:32], wd, be);
            default: ;
         endcase
      end
   endtask

   // One bus cycle: drive at the falling edge and step the model
   task automatic cyc(input bit rq, input bit we, input logic [11:0] off_b, input logic [3:0] be,
                      input logic [31:0] wd, input string name, input bit fx, input logic [31:0] fv);
      logic [ObiIdWidth-1:0] aid;
      @(negedge clk);
      aid = ObiIdWidth'($urandom_range(0, 7));
      bus_req.req = rq;
      bus_req.we = we;
      bus_req.addr = UserTimerBase | {20'd0, off_b} | 32'($urandom_range(0, 3));
      bus_req.be = be;
      bus_req.wdata = wd;
      bus_req.aid = aid;
      model_step(rq, we, off_b, be, wd, aid, name, fx, fv);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 12'h0, 4'h0, 32'h0, "idle", 0, 0);
   endtask

   task automatic wr(input logic [11:0] off_b, input logic [31:0] wd);
      cyc(1, 1, off_b, 4'hF, wd, "wr", 0, 0);
   endtask

   task automatic rd(input logic [11:0] off_b, input string name);
      cyc(1, 0, off_b, 4'h0, 32'h0, name, 0, 0);
   endtask

   task automatic rdx(input logic [11:0] off_b, input string name, input logic [31:0] v);
      cyc(1, 0, off_b, 4'h0, 32'h0, name, 1, v);
   endtask

   // Monitor: compare grant, interrupt and the response beat after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         check("gnt", bus_rsp.gnt, 1);
         check("irq", irq, m_irq);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_rvalid"}, bus_rsp.rvalid, 1);
            check({e.name, "_rdata"}, bus_rsp.rdata, e.rdata);
            check({e.name, "_err"}, bus_rsp.err, e.err);
            check({e.name, "_rid"}, bus_rsp.rid, e.rid);
         end else begin
            check("rvalid_idle", bus_rsp.rvalid, 0);
         end
      end
   end

   initial begin
      bit          rq, we;
      int          o;
      logic [11:0] off_b;
      logic [31:0] wd;
      logic [3:0]  be;

      bus_req = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;

      // Reset values
      rdx(UserTimerCmpLoOff, "rst_cmp_lo", 32'hFFFF_FFFF);
      rdx(UserTimerCmpHiOff, "rst_cmp_hi", 32'hFFFF_FFFF);
      rdx(UserTimerCountLoOff, "rst_cnt_lo", 32'h0);
      rdx(UserTimerCtrlOff, "rst_ctrl", 32'h0);
      rdx(UserTimerStatusOff, "rst_status", 32'h0);

      // Prescale 3: one increment every 4 enabled cycles
      wr(UserTimerPrescOff, 32'd3);
      wr(UserTimerCtrlOff, 32'h1);
      idle(20);
      rdx(UserTimerCountLoOff, "psc_cnt5", 32'd5);
      idle(3);
      rdx(UserTimerCountLoOff, "psc_cnt6", 32'd6);
      wr(UserTimerCtrlOff, 32'h0);

      // Match at 10 with clear-on-match and interrupt
      wr(UserTimerCountLoOff, 32'h0);
      wr(UserTimerCountHiOff, 32'h0);
      wr(UserTimerCmpLoOff, 32'd10);
      wr(UserTimerCmpHiOff, 32'h0);
      wr(UserTimerPrescOff, 32'h0);
      wr(UserTimerCtrlOff, 32'h7);
      idle(11);
      rdx(UserTimerCountLoOff, "match_cnt0", 32'h0);
      rdx(UserTimerStatusOff, "match_pend", 32'h1);
      wr(UserTimerStatusOff, 32'h1);
      rdx(UserTimerStatusOff, "w1c_pend", 32'h0);
      idle(2);
      wr(UserTimerCtrlOff, 32'h0);

      // Atomic 64-bit read across a carry
      wr(UserTimerCmpLoOff, 32'hFFFF_FFFF);
      wr(UserTimerCmpHiOff, 32'hFFFF_FFFF);
      wr(UserTimerStatusOff, 32'h1);
      wr(UserTimerCountLoOff, 32'hFFFF_FFFF);
      wr(UserTimerCountHiOff, 32'h0);
      wr(UserTimerCtrlOff, 32'h1);
      rdx(UserTimerCountLoOff, "shd_lo", 32'hFFFF_FFFF);
      rdx(UserTimerCountHiOff, "shd_hi", 32'h0);
      rdx(UserTimerCountLoOff, "shd_lo2", 32'h1);
      rdx(UserTimerCountHiOff, "shd_hi2", 32'h1);
      wr(UserTimerCtrlOff, 32'h0);

      // Byte-enable write
      cyc(1, 1, UserTimerCmpLoOff, 4'b0010, 32'h0000_AB00, "be_wr", 0, 0);
      rdx(UserTimerCmpLoOff, "be_cmp_lo", 32'hFFFF_ABFF);

      // Unmapped offset and back-to-back traffic
      rdx(12'h020, "unmap_rd", 32'h0);
      cyc(1, 1, 12'h020, 4'hF, 32'hDEAD_BEEF, "unmap_wr", 0, 0);
      rdx(UserTimerCmpLoOff, "b2b_cmp", 32'hFFFF_ABFF);
      rd(UserTimerCtrlOff, "b2b_ctrl");
      rd(UserTimerPrescOff, "b2b_psc");

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rq = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 1) == 1);
         o = $urandom_range(0, 9);
         off_b = (o <= 8) ? 12'(o * 4) : 12'hFFC;
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         if (o == 1) wd = wd & 32'h3;
         if (o == 2 || o == 4) wd = wd & 32'h3F;
         if ((o == 3 || o == 5) && $urandom_range(0, 3) != 0) wd = 32'h0;
         cyc(rq, we, off_b, be, wd, "rnd", 0, 0);
      end

      // Reset while a response beat is being presented
      wr(UserTimerCtrlOff, 32'h7);
      wr(UserTimerPrescOff, 32'h0);
      rd(UserTimerCountLoOff, "pre_rst");
      @(posedge clk);
      #3;
      rst_ni = 1'b0;
      #1;
      check("rst_rvalid", bus_rsp.rvalid, 0);
      check("rst_irq", irq, 0);
      model_reset();
      bus_req = '0;
      @(negedge clk);
      rst_ni = 1'b1;
      rdx(UserTimerCtrlOff, "post_rst_ctrl", 32'h0);
      rdx(UserTimerCmpHiOff, "post_rst_cmp", 32'hFFFF_FFFF);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
